// File: rtl/relu_backward_stream.sv
// relu_backward_stream: two-stage valid/ready float32 ReLU (forward) / ReLU gradient (backward) with optional power-of-two leaky slope
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   mode                0 = forward y = relu(x), 1 = backward dx = dy gated by x > 0
//   in_valid/in_ready   input handshake for in_data (x) and in_diff (dy), LANES float32 each
//   out_valid/out_ready output handshake for out_data (y or dx)
//   clear_count         synchronous clear of zero_count (wins over a same-cycle increment)
//   zero_count          saturating count of lanes that took the negative branch
module relu_backward_stream #(
  parameter int LANES       = 4,
  parameter int LEAKY       = 0,
  parameter int SLOPE_SHIFT = 3,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*32-1:0]   in_data,
  input  logic [LANES*32-1:0]   in_diff,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*32-1:0]   out_data,
  input  logic                  clear_count,
  output logic [CNT_W-1:0]      zero_count
);
  localparam int IW = $clog2(LANES + 1);
  localparam logic [7:0] K = 8'(SLOPE_SHIFT);
  localparam logic [CNT_W+IW-1:0] MAX = {{IW{1'b0}}, {CNT_W{1'b1}}};
  logic                  s1_valid, s2_valid, adv1, adv2, accept;
  logic [LANES-1:0]      neg, s1_neg;
  logic [LANES*32-1:0]   v, s1_v, res;
  logic [IW-1:0]         inc;
  logic [CNT_W+IW-1:0]   sum;
  logic [31:0]           sv;
  logic [7:0]            e;
  always_comb begin
    adv2 = !s2_valid | out_ready;
    adv1 = !s1_valid | adv2;
    in_ready = adv1 & !reset;
    accept = in_valid & in_ready;
    neg = '0;
    v = '0;
    inc = '0;
    for (int i = 0; i < LANES; i++) begin
      // strict x > 0: both signed zeros and every negative (incl. negative NaN) go negative
      neg[i] = in_data[32*i+31] | (in_data[32*i +: 31] == 31'h0);
      v[32*i +: 32] = mode ? in_diff[32*i +: 32] : in_data[32*i +: 32];
      inc = inc + IW'(neg[i]);
    end
    sum = {{IW{1'b0}}, zero_count} + {{CNT_W{1'b0}}, inc};
  end
  // leaky scaling by 2^-K is an exponent decrement; inf/NaN pass, tiny values flush to signed zero
  always_comb begin
    res = '0;
    sv = '0;
    e = '0;
    for (int i = 0; i < LANES; i++) begin
      sv = s1_v[32*i +: 32];
      e = sv[30:23];
      res[32*i +: 32] = !s1_neg[i] ? sv :
                        LEAKY == 0 ? 32'h0 :
                        e == 8'hff ? sv :
                        e <= K ? {sv[31], 31'b0} :
                        {sv[31], e - K, sv[22:0]};
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_neg <= '0;
      s1_v <= '0;
      out_data <= '0;
      zero_count <= '0;
    end else begin
      if (adv1) s1_valid <= accept;
      if (accept) begin
        s1_neg <= neg;
        s1_v <= v;
      end
      if (adv2) s2_valid <= s1_valid;
      if (adv2 && s1_valid) out_data <= res;
      zero_count <= clear_count ? '0 : !accept ? zero_count : sum > MAX ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end
  end
  assign out_valid = s2_valid;
endmodule
